// File: rtl/niosattempt_cpu_mul_pkg.sv
// Shared types for the sequential NIOS multiply unit:
// op encodings, sequencer states and latched bundles.
package niosattempt_cpu_mul_pkg;

  localparam int CELL_LATENCY = 1;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    CAP1   = 3'd2,
    CAP2   = 3'd3,
    SUM    = 3'd4,
    RESP   = 3'd5
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    op_e         op;
  } req_t;

  typedef struct packed {
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [31:0] p4;
  } part_t;

  function automatic logic is_mulx(op_e op);
    return op != OP_MUL;
  endfunction

endpackage

// File: rtl/niosattempt_cpu_mul_seq_if.sv
// Request/response handshake bundle of the
// sequential multiply unit.
interface niosattempt_cpu_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  modport master (
    output req_valid,
    output req_src1,
    output req_src2,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result
  );

  modport slave (
    input  req_valid,
    input  req_src1,
    input  req_src2,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result
  );
endinterface

// File: rtl/niosattempt_cpu_mul_combine.sv
// Folds the four 16x16 partials into a 64-bit product and
// applies the signed high-word corrections.
module niosattempt_cpu_mul_combine
  import niosattempt_cpu_mul_pkg::*;
(
  input  part_t       part,
  input  op_e         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [32:0] mid;
  logic [31:0] hi_part;
  logic [63:0] prod;
  logic [31:0] hi;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  always_comb begin
    mid     = {1'b0, part.p2} + {1'b0, part.p3};
    // p4 may hold a stale value from an earlier MULX
    hi_part = (op == OP_MUL) ? 32'h0 : part.p4;
    prod    = {32'h0, part.p1}
            + ({31'h0, mid} << 16)
            + {hi_part, 32'h0};
    hi      = prod[63:32];
    corr_a  = a[31] ? b : 32'h0;
    corr_b  = b[31] ? a : 32'h0;
    result  = '0;
    unique case (1'b1)
      (op == OP_MUL):    result = prod[31:0];
      (op == OP_MULXUU): result = hi;
      (op == OP_MULXSU): result = hi - corr_a;
      (op == OP_MULXSS): result = hi - corr_a - corr_b;
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/niosattempt_cpu_mul_seq.sv
// Sequencer driving an external 3-partial 16x16 multiplier
// cell for NIOS MUL/MULXUU/MULXSU/MULXSS.
module niosattempt_cpu_mul_seq
  import niosattempt_cpu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  state_e      state_q;
  state_e      state_d;
  req_t        req_q;
  part_t       part_q;
  logic [31:0] result_q;
  logic [31:0] sum_result;

  niosattempt_cpu_mul_combine u_combine (
    .part   (part_q),
    .op     (req_q.op),
    .a      (req_q.a),
    .b      (req_q.b),
    .result (sum_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      part_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        req_q.a  <= req_src1;
        req_q.b  <= req_src2;
        req_q.op <= op_e'(req_op);
      end
      if (state_q == CAP1) begin
        part_q.p1 <= cell_p1;
        part_q.p2 <= cell_p2;
        part_q.p3 <= cell_p3;
      end
      if (state_q == CAP2) begin
        part_q.p4 <= cell_p1;
      end
      if (state_q == SUM) begin
        result_q <= sum_result;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cell_en   = 1'b0;
    cell_src1 = '0;
    cell_src2 = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) state_d = ISSUE1;
      end
      ISSUE1: begin
        cell_en   = 1'b1;
        cell_src1 = req_q.a;
        cell_src2 = req_q.b;
        state_d   = CAP1;
      end
      CAP1: begin
        // second pass reuses the cell's lo*lo lane for A_hi*B_hi
        if (is_mulx(req_q.op)) begin
          cell_en   = 1'b1;
          cell_src1 = {16'h0, req_q.a[31:16]};
          cell_src2 = {16'h0, req_q.b[31:16]};
          state_d   = CAP2;
        end else begin
          state_d = SUM;
        end
      end
      CAP2: state_d = SUM;
      SUM:  state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;

endmodule

// File: tb/tb_niosattempt_cpu_mul_seq.sv
// Bench for niosattempt_cpu_mul_seq: directed vectors plus a
// cycle-level reference model checked every cycle.
module tb_niosattempt_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1 = '0;
  logic [31:0] cell_p2 = '0;
  logic [31:0] cell_p3 = '0;

  niosattempt_cpu_mul_seq_if bus ();

  niosattempt_cpu_mul_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (bus.req_valid),
    .req_ready  (bus.req_ready),
    .req_src1   (bus.req_src1),
    .req_src2   (bus.req_src2),
    .req_op     (bus.req_op),
    .rsp_valid  (bus.rsp_valid),
    .rsp_ready  (bus.rsp_ready),
    .rsp_result (bus.rsp_result),
    .cell_src1  (cell_src1),
    .cell_src2  (cell_src2),
    .cell_en    (cell_en),
    .cell_p1    (cell_p1),
    .cell_p2    (cell_p2),
    .cell_p3    (cell_p3)
  );

  always #5 clk = ~clk;

  // external 3-partial cell, one cycle latency
  always @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    logic [63:0] p;
    xa = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    xb = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // reference model: age counts cycles since the accept edge
  bit          m_busy = 0;
  int          m_age = 0;
  int          m_lat = 4;
  logic [1:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy <= 1;
        m_age  <= 1;
        m_op   <= bus.req_op;
        m_a    <= bus.req_src1;
        m_b    <= bus.req_src2;
        m_lat  <= (bus.req_op == 2'b00) ? 4 : 5;
        m_res  <= ref_mul(bus.req_op, bus.req_src1, bus.req_src2);
      end
    end else if (m_age >= m_lat && bus.rsp_ready) begin
      m_busy <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic        e_v;
    logic        e_en;
    logic [31:0] e_s1;
    logic [31:0] e_s2;
    e_v  = m_busy && m_age >= m_lat;
    e_en = 1'b0;
    e_s1 = '0;
    e_s2 = '0;
    if (m_busy && m_age == 1) begin
      e_en = 1'b1;
      e_s1 = m_a;
      e_s2 = m_b;
    end else if (m_busy && m_age == 2 && m_op != 2'b00) begin
      e_en = 1'b1;
      e_s1 = {16'h0, m_a[31:16]};
      e_s2 = {16'h0, m_b[31:16]};
    end
    chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_v));
    if (e_v) chk("rsp_result", bus.rsp_result, m_res);
    if (!reset_n) chk("rst_result", bus.rsp_result, 32'h0);
    chk("cell_en", 32'(cell_en), 32'(e_en));
    chk("cell_src1", cell_src1, e_s1);
    chk("cell_src2", cell_src2, e_s2);
  end

  logic [31:0] src_at2;

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int pulses,
                        input string nm);
    int cyc;
    int en_cnt;
    bit got;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = ~op;
    bus.req_src1  = ~a;
    bus.req_src2  = ~b;
    cyc = 0;
    en_cnt = 0;
    got = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cell_en) en_cnt++;
      if (cyc == 2) src_at2 = cell_src1;
      if (bus.rsp_valid) got = 1;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(lat));
    chk({nm, "_result"}, bus.rsp_result, exp);
    chk({nm, "_cell_pulses"}, 32'(en_cnt), 32'(pulses));
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_cell_en", 32'(cell_en), 32'h0);
    chk("rst_cell_src1", cell_src1, 32'h0);

    chk("pin_mul", ref_mul(2'b00, 32'h0001_0003, 32'h0002_0005),
        32'h000B_000F);
    chk("pin_uu", ref_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        32'hFFFF_FFFE);
    chk("pin_su", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        32'hFFFF_FFFF);
    chk("pin_ss", ref_mul(2'b11, 32'h8000_0000, 32'h2),
        32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F,
           4, 1, "mul");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
           5, 2, "mulxuu");
    chk("mulxuu_src_t2", src_at2, 32'h0000_FFFF);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           5, 2, "mulxsu");
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,
           5, 2, "mulxss_m1");
    run_op(2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF,
           5, 2, "mulxss_min");

    // long consumer stall with a competing request
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    run_op(2'b10, 32'h8000_0001, 32'h0000_0003, 32'hFFFF_FFFE,
           5, 2, "stall");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b00;
      bus.req_src1  = 32'h5;
      bus.req_src2  = 32'h7;
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
      chk("stall_result", bus.rsp_result, 32'hFFFF_FFFE);
      chk("stall_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_idle", 32'(bus.req_ready), 32'h1);
    chk("stall_dropped", 32'(bus.rsp_valid), 32'h0);

    // reset in CAP1 of a MULXUU
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_src1  = 32'h1234_5678;
    bus.req_src2  = 32'h9ABC_DEF0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(bus.req_ready), 32'h1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("abort_result", bus.rsp_result, 32'h0);
    chk("abort_cell_en", 32'(cell_en), 32'h0);
    chk("abort_cell_src2", cell_src2, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_op(2'b00, 32'd7, 32'd6, 32'd42, 4, 1, "post_rst");

    // random back-to-back stream, model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_op    = 2'($urandom_range(0, 3));
      bus.req_src1  = pick();
      bus.req_src2  = pick();
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_idle", 32'(bus.req_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
